// File: rtl/cplx_reg_bank_p_pkg.sv
// cplx_pkg: shared write-mode encodings, sweep FSM states, constant-table size and helpers.
package cplx_pkg;
    typedef enum logic [1:0] {
        WM_BOTH = 2'b00,
        WM_IM   = 2'b01,
        WM_RE   = 2'b10,
        WM_SWAP = 2'b11
    } wmode_e;
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;
    localparam int NCONST = 9;
    // Index width never drops below 4 so constant indices up to 15 stay addressable.
    function automatic int aw_of(input int n);
        return ($clog2(n) > 4) ? $clog2(n) : 4;
    endfunction
    // Constant component table R = {+1, 0, -1}.
    function automatic logic signed [1:0] rval(input int j);
        return (j == 0) ? 2'sd1 : (j == 1) ? 2'sd0 : -2'sd1;
    endfunction
endpackage

// File: rtl/cplx_reg_bank_p_if.sv
// cplx_reg_bank_p_if: bus bundle of the complex register bank.
// Write side: regwen, inA, selwreg, endwreg; control: clr_req -> busy;
// read side: selout, cnst, enrreg -> outd, outvld, cerr. master drives, slave is the bank.
interface cplx_reg_bank_p_if
    import cplx_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 16,
    parameter int NRD  = 2
);
    localparam int AW = aw_of(NREG);
    logic                  regwen;
    logic [2*DW-1:0]       inA;
    logic [AW-1:0]         selwreg;
    logic [1:0]            endwreg;
    logic                  clr_req;
    logic                  busy;
    logic [NRD*AW-1:0]     selout;
    logic [NRD-1:0]        cnst;
    logic [NRD-1:0]        enrreg;
    logic [NRD*2*DW-1:0]   outd;
    logic [NRD-1:0]        outvld;
    logic [NRD-1:0]        cerr;
    modport master (
        output regwen, inA, selwreg, endwreg, clr_req, selout, cnst, enrreg,
        input  busy, outd, outvld, cerr
    );
    modport slave (
        input  regwen, inA, selwreg, endwreg, clr_req, selout, cnst, enrreg,
        output busy, outd, outvld, cerr
    );
endinterface

// File: rtl/cplx_reg_bank_p_const_rom.sv
// cplx_const_rom: combinational constant table; idx in, data {re, im} and illegal flag out.
// Index k (0..8) gives re = R[k mod 3], im = R[k div 3]; k > 8 gives zero with illegal=1.
module cplx_const_rom
    import cplx_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic [AW-1:0]   idx,
    output logic [2*DW-1:0] data,
    output logic            illegal
);
    logic signed [DW-1:0] w_re;
    logic signed [DW-1:0] w_im;
    always_comb begin
        illegal = int'(idx) >= NCONST;
        w_re    = DW'(rval(int'(idx) % 3));
        w_im    = DW'(rval(int'(idx) / 3));
        data    = illegal ? '0 : {w_re, w_im};
    end
endmodule

// File: rtl/cplx_reg_bank_p.sv
// cplx_reg_bank_p: complex {re, im} register bank with NRD registered read ports and a clear sweep.
// Ports: clock, reset (sync, active-high), bus (cplx_reg_bank_p_if.slave).
module cplx_reg_bank_p
    import cplx_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 16,
    parameter int NRD  = 2
) (
    input logic              clock,
    input logic              reset,
    cplx_reg_bank_p_if.slave bus
);
    localparam int AW = aw_of(NREG);
    localparam int W  = 2 * DW;
    logic [W-1:0]            r_mem [NREG];
    logic [NREG-1:0]         r_val;
    state_e                  r_state;
    state_e                  w_next;
    logic [AW-1:0]           r_cnt;
    logic                    w_busy;
    logic                    w_wr_ok;
    wmode_e                  w_mode;
    logic [W-1:0]            w_old;
    logic [W-1:0]            w_wdata;
    logic [NRD-1:0][W-1:0]   w_rd;
    logic [NRD-1:0][W-1:0]   w_rom;
    logic [NRD-1:0]          w_rv;
    logic [NRD-1:0]          w_ill;
    logic [NRD-1:0][W-1:0]   r_outd;
    logic [NRD-1:0]          r_vld;
    logic [NRD-1:0]          r_cerr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == SWEEP) ? r_cnt + 1'b1 : '0;
        end
    end

    always_comb w_next = (r_state == IDLE) ? (bus.clr_req ? SWEEP : IDLE)
                                           : ((r_cnt == AW'(NREG - 1)) ? IDLE : SWEEP);

    always_comb w_busy = r_state == SWEEP;

    // Partial modes merge with the currently stored word.
    assign w_wr_ok = bus.regwen && !w_busy && (int'(bus.selwreg) < NREG);
    assign w_mode  = wmode_e'(bus.endwreg);
    assign w_old   = r_mem[bus.selwreg];
    always_comb w_wdata = (w_mode == WM_RE)   ? {bus.inA[W-1:DW], w_old[DW-1:0]} :
                          (w_mode == WM_IM)   ? {w_old[W-1:DW], bus.inA[DW-1:0]} :
                          (w_mode == WM_SWAP) ? {bus.inA[DW-1:0], bus.inA[W-1:DW]} : bus.inA;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
            r_val <= '0;
        end else if (w_busy) begin
            r_mem[r_cnt] <= '0;
            r_val[r_cnt] <= 1'b0;
        end else if (w_wr_ok) begin
            r_mem[bus.selwreg] <= w_wdata;
            r_val[bus.selwreg] <= 1'b1;
        end
    end

    // Each port forwards a same-cycle write to its index so reads see the post-write value.
    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [AW-1:0] w_sel;
        logic          w_in;
        logic          w_hit;
        assign w_sel   = bus.selout[p*AW +: AW];
        assign w_in    = int'(w_sel) < NREG;
        assign w_hit   = w_wr_ok && (bus.selwreg == w_sel);
        assign w_rd[p] = w_hit ? w_wdata : (w_in ? r_mem[w_sel] : '0);
        assign w_rv[p] = w_hit || (w_in && r_val[w_sel]);
        cplx_const_rom #(.DW(DW), .AW(AW)) u_rom (
            .idx     (w_sel),
            .data    (w_rom[p]),
            .illegal (w_ill[p])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_outd <= '0;
            r_vld  <= '0;
            r_cerr <= '0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                r_cerr[i] <= 1'b0;
                if (bus.enrreg[i] && !w_busy) begin
                    r_outd[i] <= bus.cnst[i] ? w_rom[i] : w_rd[i];
                    r_vld[i]  <= bus.cnst[i] ? !w_ill[i] : w_rv[i];
                    r_cerr[i] <= bus.cnst[i] && w_ill[i];
                end
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.outd   = r_outd;
    assign bus.outvld = r_vld;
    assign bus.cerr   = r_cerr;
endmodule

// File: tb/tb_cplx_reg_bank_p.sv
// tb_cplx_reg_bank_p: directed and random checks of cplx_reg_bank_p against a behavioural model.
module tb_cplx_reg_bank_p;
    localparam int DW = 32, NREG = 16, NRD = 2, AW = 4;
    logic clock = 1'b0;
    logic reset;
    int n_chk = 0;
    int n_err = 0;
    logic [63:0] m_mem [NREG];
    logic        m_val [NREG];
    bit          m_sweep;
    int          m_si;
    logic [63:0] e_outd [NRD];
    logic [NRD-1:0] e_vld, e_cerr;

    always #5 clock = ~clock;

    cplx_reg_bank_p_if #(.DW(DW), .NREG(NREG), .NRD(NRD)) bus ();
    cplx_reg_bank_p #(.DW(DW), .NREG(NREG), .NRD(NRD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then compare all outputs.
    task automatic cyc();
        logic [63:0] old, wd;
        logic [31:0] re, im;
        int k;
        bit busy_now;
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin m_mem[i] = '0; m_val[i] = 1'b0; end
            m_sweep = 0; m_si = 0;
            for (int p = 0; p < NRD; p++) e_outd[p] = '0;
            e_vld = '0; e_cerr = '0;
        end else begin
            busy_now = m_sweep;
            if (!busy_now && bus.regwen) begin
                old = m_mem[bus.selwreg];
                re = bus.inA[63:32];
                im = bus.inA[31:0];
                case (bus.endwreg)
                    2'b00:   wd = {re, im};
                    2'b10:   wd = {re, old[31:0]};
                    2'b01:   wd = {old[63:32], im};
                    default: wd = {im, re};
                endcase
                m_mem[bus.selwreg] = wd;
                m_val[bus.selwreg] = 1'b1;
            end
            for (int p = 0; p < NRD; p++) begin
                e_cerr[p] = 1'b0;
                if (bus.enrreg[p] && !busy_now) begin
                    k = int'(bus.selout[p*AW +: AW]);
                    if (bus.cnst[p]) begin
                        if (k < 9) begin
                            e_outd[p] = {32'(1 - k % 3), 32'(1 - k / 3)};
                            e_vld[p] = 1'b1;
                        end else begin
                            e_outd[p] = '0;
                            e_vld[p] = 1'b0;
                            e_cerr[p] = 1'b1;
                        end
                    end else begin
                        e_outd[p] = m_mem[k];
                        e_vld[p] = m_val[k];
                    end
                end
            end
            if (busy_now) begin
                m_mem[m_si] = '0;
                m_val[m_si] = 1'b0;
                m_si++;
                if (m_si == NREG) m_sweep = 0;
            end else if (bus.clr_req) begin
                m_sweep = 1;
                m_si = 0;
            end
        end
        #1;
        chk("busy", 128'(bus.busy), 128'(m_sweep));
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("outd%0d", p), 128'(bus.outd[p*64 +: 64]), 128'(e_outd[p]));
            chk($sformatf("outvld%0d", p), 128'(bus.outvld[p]), 128'(e_vld[p]));
            chk($sformatf("cerr%0d", p), 128'(bus.cerr[p]), 128'(e_cerr[p]));
        end
    endtask

    task automatic idle();
        bus.regwen = 0; bus.clr_req = 0; bus.enrreg = '0; bus.cnst = '0;
    endtask

    task automatic wr(input int idx, input logic [63:0] d, input logic [1:0] mode);
        bus.regwen = 1; bus.selwreg = AW'(idx); bus.inA = d; bus.endwreg = mode;
    endtask

    task automatic rd(input int p, input int sel, input logic c);
        bus.enrreg[p] = 1'b1; bus.cnst[p] = c; bus.selout[p*AW +: AW] = AW'(sel);
    endtask

    task automatic read_back(input int idx, input logic [63:0] exp, input string tag);
        idle(); rd(0, idx, 0); cyc();
        chk(tag, 128'(bus.outd[63:0]), 128'(exp));
        chk({tag, "_vld"}, 128'(bus.outvld[0]), 128'(1'b1));
    endtask

    task automatic fill_all();
        for (int i = 0; i < NREG; i++) begin
            idle(); wr(i, {$urandom, $urandom}, 2'b00); cyc();
        end
        idle();
    endtask

    task automatic count_busy(input string tag);
        int n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            if (n >= 4 && n <= 6) bus.clr_req = 1'b1; else bus.clr_req = 1'b0;
            wr($urandom_range(0, NREG - 1), {$urandom, $urandom}, 2'b00);
            rd(0, $urandom_range(0, NREG - 1), 0);
            cyc();
        end
        idle();
        chk(tag, 128'(n), 128'(16));
    endtask

    task automatic all_zero(input string tag);
        for (int i = 0; i < NREG; i += 2) begin
            idle(); rd(0, i, 0); rd(1, i + 1, 0); cyc();
            chk({tag, "_d0"}, 128'(bus.outd[63:0]), 128'(0));
            chk({tag, "_v1"}, 128'(bus.outvld[1]), 128'(1'b0));
        end
    endtask

    initial begin
        reset = 1;
        bus.regwen = 1; bus.inA = '1; bus.selwreg = '0; bus.endwreg = '0;
        bus.clr_req = 1; bus.selout = '0; bus.cnst = '0; bus.enrreg = '1;
        cyc(); cyc();
        reset = 0;
        idle();
        chk("rst_outd", 128'(bus.outd), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));

        idle(); wr(3, 64'h00000005_00000007, 2'b00); cyc();
        read_back(3, 64'h00000005_00000007, "wr_both");
        idle(); wr(3, 64'h00000009_00000001, 2'b10); cyc();
        read_back(3, 64'h00000009_00000007, "wr_re");
        idle(); wr(3, 64'h00000002_00000004, 2'b01); cyc();
        read_back(3, 64'h00000009_00000004, "wr_im");
        idle(); wr(3, 64'h0000000A_0000000B, 2'b11); cyc();
        read_back(3, 64'h0000000B_0000000A, "wr_swap");

        idle(); rd(0, 8, 1); rd(1, 12, 1); cyc();
        chk("const8", 128'(bus.outd[63:0]), 128'(64'hFFFFFFFF_FFFFFFFF));
        chk("const8_vld", 128'(bus.outvld[0]), 128'(1'b1));
        chk("const12", 128'(bus.outd[127:64]), 128'(0));
        chk("const12_vld", 128'(bus.outvld[1]), 128'(1'b0));
        chk("cerr_pulse", 128'(bus.cerr), 128'(2'b10));
        idle(); cyc();
        chk("cerr_drop", 128'(bus.cerr), 128'(2'b00));
        idle(); rd(0, 4, 1); rd(1, 0, 1); cyc();
        chk("const4", 128'(bus.outd[63:0]), 128'(0));
        chk("const0", 128'(bus.outd[127:64]), 128'(64'h00000001_00000001));

        idle(); wr(6, 64'h00000001_00000001, 2'b00); rd(0, 6, 0); rd(1, 6, 0); cyc();
        chk("byp0", 128'(bus.outd[63:0]), 128'(64'h00000001_00000001));
        chk("byp1", 128'(bus.outd[127:64]), 128'(64'h00000001_00000001));
        chk("byp_vld", 128'(bus.outvld), 128'(2'b11));

        fill_all();
        bus.clr_req = 1; cyc();
        count_busy("sweep_len");
        all_zero("swept");

        fill_all();
        wr(2, 64'h12345678_9ABCDEF0, 2'b00); bus.clr_req = 1; cyc();
        count_busy("sweep_wr_len");
        idle(); rd(0, 2, 0); cyc();
        chk("clr_wr_erased", 128'(bus.outd[63:0]), 128'(0));
        chk("clr_wr_vld", 128'(bus.outvld[0]), 128'(1'b0));

        fill_all();
        rd(0, 1, 0); cyc();
        bus.clr_req = 1; idle(); bus.clr_req = 1; cyc();
        bus.clr_req = 0;
        for (int i = 0; i < 5; i++) cyc();
        reset = 1; cyc(); reset = 0;
        chk("midrst_busy", 128'(bus.busy), 128'(0));
        chk("midrst_out", 128'({bus.outd, bus.outvld, bus.cerr}), 128'(0));
        idle(); wr(0, 64'h11, 2'b00); cyc();
        idle(); wr(15, 64'h22, 2'b00); cyc();
        idle(); bus.clr_req = 1; cyc();
        count_busy("restart_len");
        all_zero("restart");

        for (int t = 0; t < 400; t++) begin
            reset = ($urandom_range(0, 99) == 0);
            bus.regwen = 1'($urandom_range(0, 1));
            bus.inA = {$urandom, $urandom};
            bus.selwreg = 4'($urandom);
            bus.endwreg = 2'($urandom);
            bus.clr_req = ($urandom_range(0, 39) == 0);
            bus.selout = 8'($urandom);
            bus.cnst = 2'($urandom);
            bus.enrreg = 2'($urandom);
            cyc();
        end
        reset = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
